// File: rtl/compressed_byte_accumulator_if.sv
// compressed_byte_accumulator_if
// Token input handshake and buffered byte output bus of the byte accumulator.
// master = token producer / downstream consumer side, slave = the accumulator.
interface compressed_byte_accumulator_if #(
    parameter int BUFFER_DEPTH           = 34,
    parameter int NUM_BYTES_OUTPUT_WIDTH = 16,
    parameter int MAX_TOKEN_BYTES        = 8
);
    localparam int CW = $clog2(BUFFER_DEPTH);
    localparam int LW = $clog2(MAX_TOKEN_BYTES + 1);

    logic [MAX_TOKEN_BYTES-1:0][7:0]        tokenIn;
    logic [LW-1:0]                          tokenLen;
    logic                                   tokenLast;
    logic                                   tokenValid;
    logic                                   tokenReady;
    logic [NUM_BYTES_OUTPUT_WIDTH-1:0][7:0] dataOut;
    logic [CW-1:0]                          dataOutBytesValid;
    logic                                   dataOutShift;
    logic                                   endOfStream;

    modport master (
        output tokenIn, tokenLen, tokenLast, tokenValid, dataOutShift,
        input  tokenReady, dataOut, dataOutBytesValid, endOfStream
    );

    modport slave (
        input  tokenIn, tokenLen, tokenLast, tokenValid, dataOutShift,
        output tokenReady, dataOut, dataOutBytesValid, endOfStream
    );
endinterface

// File: rtl/compressed_byte_accumulator.sv
// compressed_byte_accumulator
// Packs variable-length compressed tokens into a byte shift buffer, presents
// the lowest lanes downstream, and drains/flags end of stream.
// Optional feature macro: ACC_BYTECOUNT_EN adds the 32-bit byteCount output.
// Invariant: buffer bytes at index >= count are always zero, so dataOut is a
// plain register slice with unused lanes already reading 0x00.
module compressed_byte_accumulator #(
    parameter int BUFFER_DEPTH           = 34,
    parameter int NUM_BYTES_OUTPUT_WIDTH = 16,
    parameter int MAX_TOKEN_BYTES        = 8
) (
    input  logic clk,
    input  logic reset,
    compressed_byte_accumulator_if.slave bus
`ifdef ACC_BYTECOUNT_EN
    ,
    output logic [31:0] byteCount
`endif
);
    localparam int CW = $clog2(BUFFER_DEPTH);
    localparam logic [CW:0] READY_LIMIT = (CW+1)'(BUFFER_DEPTH - MAX_TOKEN_BYTES);
    localparam logic [CW:0] OUT_LANES   = (CW+1)'(NUM_BYTES_OUTPUT_WIDTH);
    localparam logic [CW:0] MAX_LEN     = (CW+1)'(MAX_TOKEN_BYTES);
    localparam logic [CW:0] DEPTH_EXT   = (CW+1)'(BUFFER_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, EOS} state_t;

    state_t                       state_q, state_d;
    logic [BUFFER_DEPTH-1:0][7:0] buf_q, buf_d;
    logic [CW-1:0]                count_q, count_d;

    logic [CW:0] count_ext;
    logic [CW:0] shift_amt;
    logic [CW:0] accept_len;
    logic [CW:0] token_len_ext;
    logic [CW:0] write_base;
    logic [CW:0] count_sum;
    logic [CW:0] src_idx;
    logic [CW:0] dst_idx;
    logic        token_ready;
    logic        accept;

    // Handshake and per-cycle shift/accept amounts; ready depends on registers only
    always_comb begin
        count_ext     = {1'b0, count_q};
        token_ready   = (state_q == RUN) && (count_ext <= READY_LIMIT);
        accept        = bus.tokenValid && token_ready;
        token_len_ext = (CW+1)'(bus.tokenLen);
        shift_amt     = '0;
        accept_len    = '0;
        if (bus.dataOutShift) begin
            shift_amt = (count_ext > OUT_LANES) ? OUT_LANES : count_ext;
        end
        if (accept) begin
            accept_len = (token_len_ext > MAX_LEN) ? MAX_LEN : token_len_ext;
        end
        write_base = count_ext - shift_amt;
        count_sum  = write_base + accept_len;
        count_d    = count_sum[CW-1:0];
    end

    // Shift surviving bytes down, then land the accepted token right after them
    always_comb begin
        buf_d   = '0;
        src_idx = '0;
        dst_idx = '0;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            src_idx = (CW+1)'(i) + shift_amt;
            if (src_idx < DEPTH_EXT) begin
                buf_d[i] = buf_q[src_idx[CW-1:0]];
            end
        end
        for (int j = 0; j < MAX_TOKEN_BYTES; j++) begin
            dst_idx = write_base + (CW+1)'(j);
            if (((CW+1)'(j) < accept_len) && (dst_idx < DEPTH_EXT)) begin
                buf_d[dst_idx[CW-1:0]] = bus.tokenIn[j];
            end
        end
    end

    // Stream control: run until the last token, drain to empty, flag one EOS cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && bus.tokenLast) state_d = DRAIN;
            DRAIN:   if (count_q == '0)           state_d = EOS;
            EOS:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Buffer, fill count and stream state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

`ifdef ACC_BYTECOUNT_EN
    logic [31:0] byte_count_q, byte_count_d;

    // Running total of bytes consumed downstream, wraps naturally at 2^32
    always_comb begin
        byte_count_d = byte_count_q + 32'(shift_amt);
    end

    // Byte counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byteCount = byte_count_q;
`endif

    assign bus.tokenReady        = token_ready;
    assign bus.dataOut           = buf_q[NUM_BYTES_OUTPUT_WIDTH-1:0];
    assign bus.dataOutBytesValid = count_q;
    assign bus.endOfStream       = (state_q == EOS);
endmodule

// File: tb/tb_compressed_byte_accumulator.sv
// tb_compressed_byte_accumulator
// Scoreboard bench: a byte-queue model predicts count/lanes/ready/EOS for each
// driven cycle; each test task pops the prediction after the edge and checks.
// Honours ACC_BYTECOUNT_EN for the byteCount output.
module tb_compressed_byte_accumulator;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    compressed_byte_accumulator_if #(
        .BUFFER_DEPTH(34), .NUM_BYTES_OUTPUT_WIDTH(16), .MAX_TOKEN_BYTES(8)
    ) bus ();

`ifdef ACC_BYTECOUNT_EN
    logic [31:0] byte_count;
`endif

    compressed_byte_accumulator #(
        .BUFFER_DEPTH(34), .NUM_BYTES_OUTPUT_WIDTH(16), .MAX_TOKEN_BYTES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ACC_BYTECOUNT_EN
        ,
        .byteCount(byte_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   cnt;
        logic [127:0] lanes;
        logic         eos;
        logic         rdy;
        logic [31:0]  bc;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[$];
    int         mstate = 0;
    logic [31:0] mbc = '0;

    // Synchronous reset for one edge and clear the model
    task automatic do_reset();
        bus.tokenValid = 1'b0;
        bus.tokenLen = '0;
        bus.tokenLast = 1'b0;
        bus.tokenIn = '0;
        bus.dataOutShift = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        expq.delete();
        mstate = 0;
        mbc = '0;
    endtask

    // Drive one cycle, predict the post-edge outputs, push them, advance
    task automatic drive_cycle(input logic v, input logic [3:0] len, input logic last,
                               input logic sh, input logic [63:0] tok);
        int size0;
        int n;
        int l;
        logic rdy;
        logic acc;
        exp_t e;
        bus.tokenValid = v;
        bus.tokenLen = len;
        bus.tokenLast = last;
        bus.dataOutShift = sh;
        bus.tokenIn = tok;
        size0 = mq.size();
        rdy = (mstate == 0) && (size0 <= 26);
        acc = v && rdy;
        n = sh ? ((size0 < 16) ? size0 : 16) : 0;
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        mbc = mbc + 32'(n);
        l = (len > 4'd8) ? 8 : int'(len);
        if (acc) for (int k = 0; k < l; k++) mq.push_back(tok[8*k +: 8]);
        if (mstate == 0 && acc && last) mstate = 1;
        else if (mstate == 1 && size0 == 0) mstate = 2;
        else if (mstate == 2) mstate = 0;
        e.cnt = 6'(mq.size());
        e.lanes = '0;
        for (int k = 0; k < mq.size() && k < 16; k++) e.lanes[8*k +: 8] = mq[k];
        e.eos = (mstate == 2);
        e.rdy = (mstate == 0) && (mq.size() <= 26);
        e.bc = mbc;
        expq.push_back(e);
        @(posedge clk);
        #1;
        bus.tokenValid = 1'b0;
        bus.tokenLast = 1'b0;
        bus.dataOutShift = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        total++; if (bus.tokenReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", bus.tokenReady); end
        total++; if (bus.dataOutBytesValid !== 6'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bus.dataOutBytesValid); end
        total++; if (bus.dataOut !== 128'h0) begin bad++; $display("[TB] FAIL reset_lanes got=%h want=0", bus.dataOut); end
        total++; if (bus.endOfStream !== 1'b0) begin bad++; $display("[TB] FAIL reset_eos got=%b want=0", bus.endOfStream); end
`ifdef ACC_BYTECOUNT_EN
        total++; if (byte_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_bytecount got=%0d want=0", byte_count); end
`endif
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b1, 64'h0);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== e.cnt || bus.tokenReady !== e.rdy) begin
            bad++; $display("[TB] FAIL empty_shift got cnt=%0d rdy=%b want cnt=%0d rdy=%b",
                            bus.dataOutBytesValid, bus.tokenReady, e.cnt, e.rdy);
        end
    endtask

    task automatic test_fill();
        exp_t e;
        logic [63:0] tok;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 8; k++) tok[8*k +: 8] = 8'(8*t + k);
            drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, tok);
            e = expq.pop_front();
            total++; if (bus.dataOutBytesValid !== e.cnt || bus.dataOut !== e.lanes) begin
                bad++; $display("[TB] FAIL fill_step%0d got cnt=%0d lanes=%h want cnt=%0d lanes=%h",
                                t, bus.dataOutBytesValid, bus.dataOut, e.cnt, e.lanes);
            end
        end
        total++; if (bus.dataOutBytesValid !== 6'd32) begin bad++; $display("[TB] FAIL fill_count got=%0d want=32", bus.dataOutBytesValid); end
        total++; if (bus.tokenReady !== 1'b0) begin bad++; $display("[TB] FAIL fill_ready got=%b want=0", bus.tokenReady); end
        total++; if (bus.dataOut !== 128'h0f0e0d0c0b0a09080706050403020100) begin
            bad++; $display("[TB] FAIL fill_lanes got=%h want=0f0e..00", bus.dataOut);
        end
        drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== e.cnt || bus.dataOut !== e.lanes) begin
            bad++; $display("[TB] FAIL fill_blocked got cnt=%0d lanes=%h want cnt=%0d lanes=%h",
                            bus.dataOutBytesValid, bus.dataOut, e.cnt, e.lanes);
        end
    endtask

    task automatic test_shift_accept();
        exp_t e;
        do_reset();
        drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, 64'h0706050403020100);
        drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, 64'h0f0e0d0c0b0a0908);
        drive_cycle(1'b1, 4'd4, 1'b0, 1'b0, 64'hEEEEEEEE13121110);
        expq.delete();
        total++; if (bus.dataOutBytesValid !== 6'd20) begin bad++; $display("[TB] FAIL sa_setup got=%0d want=20", bus.dataOutBytesValid); end
        drive_cycle(1'b1, 4'd5, 1'b0, 1'b1, 64'h5555_55A4_A3A2_A1A0);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== 6'd9) begin bad++; $display("[TB] FAIL sa_count got=%0d want=9", bus.dataOutBytesValid); end
        total++; if (bus.dataOut !== 128'h00000000000000A4A3A2A1A013121110) begin
            bad++; $display("[TB] FAIL sa_lanes got=%h want=%h", bus.dataOut, 128'h00000000000000A4A3A2A1A013121110);
        end
        total++; if (bus.dataOut !== e.lanes) begin bad++; $display("[TB] FAIL sa_model got=%h want=%h", bus.dataOut, e.lanes); end
    endtask

    task automatic test_partial_shift();
        exp_t e;
        do_reset();
        drive_cycle(1'b1, 4'd3, 1'b0, 1'b0, 64'h0000_0000_0033_2211);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== 6'd3) begin bad++; $display("[TB] FAIL ps_setup got=%0d want=3", bus.dataOutBytesValid); end
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b1, 64'h0);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== 6'd0) begin bad++; $display("[TB] FAIL ps_count got=%0d want=0", bus.dataOutBytesValid); end
        total++; if (bus.dataOut !== 128'h0) begin bad++; $display("[TB] FAIL ps_lanes got=%h want=0", bus.dataOut); end
`ifdef ACC_BYTECOUNT_EN
        total++; if (byte_count !== 32'd3 || byte_count !== e.bc) begin bad++; $display("[TB] FAIL ps_bytecount got=%0d want=3", byte_count); end
`endif
    endtask

    task automatic test_clamp();
        exp_t e;
        do_reset();
        drive_cycle(1'b1, 4'd12, 1'b0, 1'b0, 64'h8877665544332211);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== 6'd8 || bus.dataOut !== e.lanes) begin
            bad++; $display("[TB] FAIL clamp got cnt=%0d lanes=%h want cnt=8 lanes=%h", bus.dataOutBytesValid, bus.dataOut, e.lanes);
        end
    endtask

    task automatic test_end_of_stream();
        exp_t e;
        logic [5:0] want_cnt [4] = '{6'd4, 6'd0, 6'd0, 6'd0};
        logic       want_eos [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       want_rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       want_sh  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, 64'h0807060504030201);
        drive_cycle(1'b1, 4'd6, 1'b0, 1'b0, 64'h00000E0D0C0B0A09);
        expq.delete();
        drive_cycle(1'b1, 4'd6, 1'b1, 1'b0, 64'h0000141312111110);
        e = expq.pop_front();
        total++; if (bus.dataOutBytesValid !== 6'd20 || bus.tokenReady !== 1'b0) begin
            bad++; $display("[TB] FAIL eos_last got cnt=%0d rdy=%b want cnt=20 rdy=0", bus.dataOutBytesValid, bus.tokenReady);
        end
        for (int s = 0; s < 4; s++) begin
            drive_cycle(1'b1, 4'd1, 1'b0, want_sh[s], 64'h77);
            e = expq.pop_front();
            total++;
            if (bus.dataOutBytesValid !== want_cnt[s] || bus.endOfStream !== want_eos[s] ||
                bus.tokenReady !== want_rdy[s] || bus.endOfStream !== e.eos) begin
                bad++; $display("[TB] FAIL eos_step%0d got cnt=%0d eos=%b rdy=%b want cnt=%0d eos=%b rdy=%b",
                                s, bus.dataOutBytesValid, bus.endOfStream, bus.tokenReady,
                                want_cnt[s], want_eos[s], want_rdy[s]);
            end
        end
    endtask

    task automatic test_empty_stream();
        exp_t e;
        logic want_eos [3] = '{1'b0, 1'b1, 1'b0};
        logic want_rdy [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            drive_cycle(s == 0, 4'd0, s == 0, 1'b0, 64'h0);
            e = expq.pop_front();
            total++;
            if (bus.endOfStream !== want_eos[s] || bus.tokenReady !== want_rdy[s] || bus.dataOutBytesValid !== 6'd0) begin
                bad++; $display("[TB] FAIL empty_step%0d got eos=%b rdy=%b cnt=%0d want eos=%b rdy=%b cnt=0",
                                s, bus.endOfStream, bus.tokenReady, bus.dataOutBytesValid, want_eos[s], want_rdy[s]);
            end
        end
    endtask

    task automatic test_reset_drain();
        exp_t e;
        do_reset();
        drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, 64'h1111111111111111);
        drive_cycle(1'b1, 4'd4, 1'b1, 1'b0, 64'h0000000022222222);
        total++; if (bus.dataOutBytesValid !== 6'd12 || bus.tokenReady !== 1'b0) begin
            bad++; $display("[TB] FAIL rd_setup got cnt=%0d rdy=%b want cnt=12 rdy=0", bus.dataOutBytesValid, bus.tokenReady);
        end
        do_reset();
        total++; if (bus.dataOutBytesValid !== 6'd0 || bus.tokenReady !== 1'b1 || bus.endOfStream !== 1'b0 || bus.dataOut !== 128'h0) begin
            bad++; $display("[TB] FAIL rd_after got cnt=%0d rdy=%b eos=%b want cnt=0 rdy=1 eos=0",
                            bus.dataOutBytesValid, bus.tokenReady, bus.endOfStream);
        end
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 64'h0);
        e = expq.pop_front();
        total++; if (bus.endOfStream !== 1'b0 || bus.endOfStream !== e.eos) begin
            bad++; $display("[TB] FAIL rd_no_eos got=%b want=0", bus.endOfStream);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 8)), 1'b0,
                        1'($urandom_range(0, 2) == 0), {$urandom, $urandom});
            e = expq.pop_front();
            total++;
            if (bus.dataOutBytesValid !== e.cnt || bus.dataOut !== e.lanes || bus.tokenReady !== e.rdy) begin
                bad++; $display("[TB] FAIL b2b_cycle%0d got cnt=%0d rdy=%b lanes=%h want cnt=%0d rdy=%b lanes=%h",
                                c, bus.dataOutBytesValid, bus.tokenReady, bus.dataOut, e.cnt, e.rdy, e.lanes);
            end
`ifdef ACC_BYTECOUNT_EN
            total++;
            if (byte_count !== e.bc) begin bad++; $display("[TB] FAIL b2b_bytecount%0d got=%0d want=%0d", c, byte_count, e.bc); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_shift_accept();
        test_partial_shift();
        test_clamp();
        test_end_of_stream();
        test_empty_stream();
        test_reset_drain();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
